// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter/rotator: SLL, SRL, SRA, ROL, ROR with an elastic,
// flushable STAGES-deep pipeline and a sideband tag carried alongside each op.
module pipelined_shifter #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAGW   = 5,
  parameter int LOG2W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_shamt,
  input  logic [2:0]       in_mode,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0]  out_tag,
  output logic             busy
);

  localparam int LAST  = STAGES - 1;
  localparam int BASE  = LOG2W / STAGES;
  localparam int EXTRA = LOG2W % STAGES;

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b100;
  localparam logic [2:0] MODE_ROR = 3'b101;

  // First mux level handled by stage k; earlier stages take one extra level
  // when LOG2W does not divide evenly.
  function automatic int lvl_lo(input int k);
    return k * BASE + ((k < EXTRA) ? k : EXTRA);
  endfunction

  function automatic logic [WIDTH-1:0] shift_levels(
    input logic [WIDTH-1:0] a,
    input logic [LOG2W-1:0] sh,
    input logic [2:0]       mode,
    input int               k
  );
    logic [WIDTH-1:0]        r;
    logic signed [WIDTH-1:0] sr;
    int                      lo;
    int                      hi;
    int                      amt;
    r  = a;
    lo = lvl_lo(k);
    hi = lvl_lo(k + 1);
    for (int i = 0; i < LOG2W; i++) begin
      amt = 1 << i;
      if (i >= lo && i < hi && sh[i]) begin
        case (mode)
          MODE_SLL: r = r << amt;
          MODE_SRL: r = r >> amt;
          MODE_SRA: begin
            sr = r;
            r  = sr >>> amt;
          end
          MODE_ROL: r = (r << amt) | (r >> (WIDTH - amt));
          MODE_ROR: r = (r >> amt) | (r << (WIDTH - amt));
          default:  r = r;
        endcase
      end
    end
    return r;
  endfunction

  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  dat [STAGES];
  logic [LOG2W-1:0]  sha [STAGES];
  logic [2:0]        md  [STAGES];
  logic [TAGW-1:0]   tag [STAGES];
  logic [WIDTH-1:0]  nxt [STAGES];
  logic [STAGES-1:0] rdy;
  logic              all_full;

  always_comb begin
    nxt[0] = shift_levels(in_data, in_shamt, in_mode, 0);
    for (int k = 1; k < STAGES; k++) begin
      nxt[k] = shift_levels(dat[k-1], sha[k-1], md[k-1], k);
    end
  end

  // Stage k may load when out_ready is high or some stage from k onward is
  // empty; written in closed form so there is no chained feedback through rdy.
  always_comb begin
    rdy      = '0;
    all_full = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      all_full = 1'b1;
      for (int j = k; j < STAGES; j++) begin
        all_full = all_full & vld[j];
      end
      rdy[k] = out_ready | ~all_full;
    end
  end

  // Handshake: a transfer happens at a rising edge where valid and ready are
  // both high. in_ready is held low during flush so an op offered then is never
  // taken; out_valid/out_data/out_tag come straight from the last stage registers.
  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = vld[LAST];
  assign out_data  = dat[LAST];
  assign out_tag   = tag[LAST];
  assign busy      = |vld;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dat[k] <= '0;
        sha[k] <= '0;
        md[k]  <= '0;
        tag[k] <= '0;
      end
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (rdy[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          dat[0] <= nxt[0];
          sha[0] <= in_shamt;
          md[0]  <= in_mode;
          tag[0] <= in_tag;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) begin
            dat[k] <= nxt[k];
            sha[k] <= sha[k-1];
            md[k]  <= md[k-1];
            tag[k] <= tag[k-1];
          end
        end
      end
    end
  end

endmodule
